// File: rtl/pc_unit.sv
// Program counter with RUN/HALT/FAULT control and a saturating fetch counter.
// PC_ALIGN_CHECK_EN enables the misaligned-target fault; otherwise targets are word-aligned.
module pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          COUNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        NextPC,
  input  logic               Stall,
  input  logic               Halt,
  input  logic               Resume,
  output logic [31:0]        PC,
  output logic [31:0]        PC_Plus4,
  output logic               Running,
  output logic               Faulted,
  output logic [31:0]        FaultAddr,
  output logic [COUNT_W-1:0] FetchCount
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_HALT  = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] cnt_inc;
  logic               advance;
  logic [31:0]        target;

  // Counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign advance = (state_q == S_RUN) && !Halt && !Stall;

`ifdef PC_ALIGN_CHECK_EN
  logic [31:0] fa_q, fa_d;
  logic        misal;

  assign misal  = advance && (NextPC[1:0] != 2'b00);
  assign target = NextPC;
`else
  logic unused_nextpc_lsb;

  assign unused_nextpc_lsb = ^NextPC[1:0];
  assign target            = {NextPC[31:2], 2'b00};
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
`ifdef PC_ALIGN_CHECK_EN
    fa_d    = fa_q;
`endif
    case (state_q)
      S_RUN: begin
`ifdef PC_ALIGN_CHECK_EN
        if (misal) begin
          state_d = S_FAULT;
          fa_d    = NextPC;
        end else
`endif
        if (Halt) begin
          state_d = S_HALT;
        end else if (advance) begin
          pc_d  = target;
          cnt_d = cnt_inc;
        end
      end
      S_HALT: begin
        if (Resume) state_d = S_RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fa_q <= 32'h0;
    else       fa_q <= fa_d;
  end

  assign Faulted   = (state_q == S_FAULT);
  assign FaultAddr = fa_q;
`else
  assign Faulted   = 1'b0;
  assign FaultAddr = 32'h0;
`endif

  assign PC         = pc_q;
  assign PC_Plus4   = pc_q + 32'd4;
  assign Running    = (state_q == S_RUN);
  assign FetchCount = cnt_q;

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter: RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: COUNT_W, 32, width of the retired-fetch counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 NextPC  input  32  next-PC candidate from the jump-register select stage.
REQ-006 Stall  input  1  hold PC this cycle, no count.
REQ-007 Halt  input  1  request entry to HALT (decoded halt/syscall).
REQ-008 Resume  input  1  leave HALT.
REQ-009 PC  output  32  current fetch address.
REQ-010 PC_Plus4  output  32  PC + 4, combinational, wraps modulo 2^32.
REQ-011 Running  output  1  high only in RUN.
REQ-012 Faulted  output  1  high only in FAULT.
REQ-013 FaultAddr  output  32  offending NextPC captured on fault entry.
REQ-014 FetchCount  output  COUNT_W  number of PC advances since reset.

Function
REQ-015 The unit SHALL implement states RUN, HALT, FAULT; encoding is free.
REQ-016 In RUN, per cycle, priority SHALL be: fault > Halt > Stall > advance.
REQ-017 Advance: PC <= NextPC, FetchCount += 1, one-cycle latency (NextPC at edge n visible on PC after edge n).
REQ-018 Stall in RUN: PC and FetchCount SHALL hold; state stays RUN.
REQ-019 Halt in RUN: next state HALT; PC and FetchCount hold (the halting cycle does not advance).
REQ-020 In HALT: PC, FetchCount hold; Stall and Halt ignored; Resume moves to RUN with no PC update in that cycle; first advance occurs the following cycle.
REQ-021 Halt and Resume both high in HALT: Resume wins, state RUN.
REQ-022 FAULT SHALL be absorbing: exit only by reset; PC, FetchCount, FaultAddr hold; all inputs ignored.
REQ-023 FetchCount SHALL saturate at all-ones, never wrap.
REQ-024 PC_Plus4 of 32'hFFFF_FFFC SHALL be 32'h0000_0000.
REQ-025 Outputs PC, Running, Faulted, FaultAddr, FetchCount SHALL be registered or direct decodes of registered state; no combinational path from inputs except PC_Plus4 from PC.

Reset
REQ-026 On reset assertion, without waiting for clk: PC = RESET_VECTOR, state RUN, Running = 1, Faulted = 0, FaultAddr = 0, FetchCount = 0.
REQ-027 Reset mid-HALT or mid-FAULT SHALL return to RUN with the above values; first advance occurs on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro PC_ALIGN_CHECK_EN SHALL control misalignment checking.
REQ-029 Defined: an advance with NextPC[1:0] != 0 SHALL enter FAULT, capture FaultAddr = NextPC, leave PC and FetchCount unchanged; checked only when an advance would occur (not when stalled, halting, or in HALT/FAULT).
REQ-030 Undefined: no FAULT state reachable, Faulted tied 0, FaultAddr tied 0; advance loads {NextPC[31:2], 2'b00}.

Verification
REQ-031 Reset, NextPC = 4,8,12 over three clean cycles -> PC 0,4,8,12; FetchCount 3; PC_Plus4 = 16.
REQ-032 PC = 8, Stall high 2 cycles with NextPC = 12 -> PC stays 8, FetchCount unchanged, then advances to 12 on release.
REQ-033 PC = 12, Halt pulse -> Running 0, PC 12 held 5 cycles despite NextPC toggling; Resume -> Running 1, next edge PC = NextPC.
REQ-034 With PC_ALIGN_CHECK_EN, NextPC = 32'h0000_0022 -> Faulted 1, FaultAddr 32'h22, PC unchanged; reset pulse mid-cycle -> PC 0, Faulted 0 before next edge. Without macro -> PC = 32'h20, Faulted 0.
REQ-035 COUNT_W = 4, 20 advances -> FetchCount saturates at 4'hF.
REQ-036 PC forced to 32'hFFFF_FFFC via NextPC -> PC_Plus4 = 0; Halt and Resume asserted together in HALT -> RUN next cycle.
